// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer write scheduler.
package fb_pkg;

   localparam int unsigned H_RES    = 640;
   localparam int unsigned V_RES    = 480;
   localparam int unsigned FB_WORDS = 307200;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      SWAP  = 2'd3
   } sched_state_t;

   typedef struct packed {
      logic [18:0] addr;
      logic [3:0]  color;
   } pix_t;

   // Row-major linear address: y*h_res + x.
   function automatic logic [18:0] lin_addr(input logic [9:0] x, input logic [8:0] y,
                                            input logic [18:0] h_res);
      return ({10'd0, y} * h_res) + {9'd0, x};
   endfunction

endpackage

// File: rtl/fb_pix_fifo.sv
// First-word-fall-through pixel FIFO. The head entry is visible on dout
// whenever the FIFO is non-empty. A push while full or a pop while empty is ignored.
module fb_pix_fifo
   import fb_pkg::*;
#(
   parameter int unsigned DEPTH = 16
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  pix_t                     din,
   input  logic                     pop,
   output pix_t                     dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   DEPTH_C = DEPTH[PTR_W:0];
   localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

   pix_t             mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Qualify push/pop against the current fill level.
   always_comb begin
      push_ok_s = push && (count_r != DEPTH_C);
      pop_ok_s  = pop && (count_r != {(PTR_W+1){1'b0}});
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {(PTR_W+1){1'b0}};
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push_ok_s) mem_r[wr_ptr_r] <= din;
   end

   assign dout  = mem_r[rd_ptr_r];
   assign count = count_r;
   assign empty = (count_r == {(PTR_W+1){1'b0}});
   assign full  = (count_r == DEPTH_C);

endmodule

// File: rtl/fb_write_scheduler.sv
// Arbitrates line-drawer and overlay pixel writes into the frame buffer,
// clips off-screen pixels, buffers accepted pixels and sequences the
// vggo / drain / halt frame handshake so no pixel lands after a buffer swap.
module fb_write_scheduler
   import fb_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned H_RES      = fb_pkg::H_RES,
   parameter int unsigned V_RES      = fb_pkg::V_RES,
   parameter int unsigned SWAP_WAIT  = 3
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        vg_valid,
   output logic        vg_ready,
   input  logic [9:0]  vg_x,
   input  logic [8:0]  vg_y,
   input  logic [3:0]  vg_color,
   input  logic        ov_valid,
   output logic        ov_ready,
   input  logic [9:0]  ov_x,
   input  logic [8:0]  ov_y,
   input  logic [3:0]  ov_color,
   input  logic        vggo_in,
   input  logic        frame_done,
   output logic        vggo_out,
   output logic        halt_out,
   output logic        en_w,
   output logic [18:0] w_addr,
   output logic [3:0]  color_out,
   output logic        busy,
   output logic [15:0] clip_count,
   output logic        seq_err
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned SC_W  = ($clog2(SWAP_WAIT) < 2) ? 2 : $clog2(SWAP_WAIT);
   localparam logic [SC_W-1:0] SWAP_LAST = SC_W'(SWAP_WAIT - 1);
   localparam logic [SC_W-1:0] SC_ONE    = {{(SC_W-1){1'b0}}, 1'b1};
   localparam logic [18:0]     H_RES_W   = 19'(H_RES);

   sched_state_t     state_r;
   logic [SC_W-1:0]  swap_cnt_r;
   logic             vggo_prev_r;
   logic             done_prev_r;
   logic             vggo_rise_s;
   logic             done_rise_s;
   logic             rr_vg_r;
   logic             stage_valid_r;
   pix_t             stage_pix_r;
   pix_t             fifo_dout_s;
   logic [CNT_W-1:0] fifo_count_s;
   logic             fifo_empty_s;
   logic             fifo_full_s;
   logic             push_s;
   logic             pop_s;
   logic             space_s;
   logic             run_s;
   logic             vg_hs_s;
   logic             ov_hs_s;
   logic             hs_s;
   logic             in_range_s;
   logic [9:0]       sel_x_s;
   logic [8:0]       sel_y_s;
   logic [3:0]       sel_color_s;
   logic             vggo_out_r;
   logic             halt_r;
   logic             busy_r;
   logic             seq_err_r;
   logic [15:0]      clip_cnt_r;
   logic             en_w_r;
   logic [18:0]      w_addr_r;
   logic [3:0]       color_r;

   // Edge detection, arbitration, handshake and clipping decode.
   always_comb begin
      vggo_rise_s = vggo_in & ~vggo_prev_r;
      done_rise_s = frame_done & ~done_prev_r;
      run_s       = (state_r == RUN);
      // Stage occupancy is counted so a staged pixel always finds a FIFO slot.
      space_s     = (32'(fifo_count_s) + 32'(stage_valid_r)) < FIFO_DEPTH;
      vg_hs_s     = run_s & space_s & vg_valid & (~ov_valid | rr_vg_r);
      ov_hs_s     = run_s & space_s & ov_valid & (~vg_valid | ~rr_vg_r);
      hs_s        = vg_hs_s | ov_hs_s;
      if (vg_hs_s) begin
         sel_x_s     = vg_x;
         sel_y_s     = vg_y;
         sel_color_s = vg_color;
      end else begin
         sel_x_s     = ov_x;
         sel_y_s     = ov_y;
         sel_color_s = ov_color;
      end
      in_range_s  = (32'(sel_x_s) < H_RES) && (32'(sel_y_s) < V_RES);
      push_s      = stage_valid_r & ~fifo_full_s;
      pop_s       = ~fifo_empty_s;
   end

   assign vg_ready = vg_hs_s;
   assign ov_ready = ov_hs_s;

   // Round-robin pointer: after a two-way contention, favour the loser next time.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_vg_r <= 1'b1;
      end else if (run_s && space_s && vg_valid && ov_valid) begin
         rr_vg_r <= ov_hs_s;
      end
   end

   // Address stage: linearise in-range pixels; off-screen pixels never enter the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_valid_r <= 1'b0;
         stage_pix_r   <= '{addr: 19'd0, color: 4'd0};
      end else if (hs_s && in_range_s) begin
         stage_valid_r <= 1'b1;
         stage_pix_r   <= '{addr: lin_addr(sel_x_s, sel_y_s, H_RES_W), color: sel_color_s};
      end else begin
         stage_valid_r <= 1'b0;
      end
   end

   fb_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .din   (stage_pix_r),
      .pop   (pop_s),
      .dout  (fifo_dout_s),
      .count (fifo_count_s),
      .empty (fifo_empty_s),
      .full  (fifo_full_s)
   );

   // Write port: one registered frame-buffer write per FIFO pop; data holds otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_w_r   <= 1'b0;
         w_addr_r <= 19'd0;
         color_r  <= 4'd0;
      end else begin
         en_w_r <= pop_s;
         if (pop_s) begin
            w_addr_r <= fifo_dout_s.addr;
            color_r  <= fifo_dout_s.color;
         end
      end
   end

   // Frame sequencer with registered pulse, status and clip-count outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         swap_cnt_r  <= {SC_W{1'b0}};
         vggo_prev_r <= 1'b0;
         done_prev_r <= 1'b0;
         vggo_out_r  <= 1'b0;
         halt_r      <= 1'b0;
         busy_r      <= 1'b0;
         seq_err_r   <= 1'b0;
         clip_cnt_r  <= 16'd0;
      end else begin
         vggo_prev_r <= vggo_in;
         done_prev_r <= frame_done;
         vggo_out_r  <= 1'b0;
         halt_r      <= 1'b0;
         if (hs_s && !in_range_s && (clip_cnt_r != 16'hFFFF)) begin
            clip_cnt_r <= clip_cnt_r + 16'd1;
         end
         case (state_r)
            IDLE: begin
               if (vggo_rise_s) begin
                  vggo_out_r <= 1'b1;
                  clip_cnt_r <= 16'd0;
                  state_r    <= RUN;
                  busy_r     <= 1'b1;
               end else begin
                  busy_r     <= 1'b0;
               end
            end
            RUN: begin
               busy_r <= 1'b1;
               if (vggo_rise_s) seq_err_r <= 1'b1;
               if (done_rise_s) state_r <= DRAIN;
            end
            DRAIN: begin
               busy_r <= 1'b1;
               if (vggo_rise_s) seq_err_r <= 1'b1;
               if (!stage_valid_r && fifo_empty_s) begin
                  halt_r     <= 1'b1;
                  swap_cnt_r <= {SC_W{1'b0}};
                  state_r    <= SWAP;
               end
            end
            SWAP: begin
               if (vggo_rise_s) seq_err_r <= 1'b1;
               if (swap_cnt_r == SWAP_LAST) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  swap_cnt_r <= swap_cnt_r + SC_ONE;
                  busy_r     <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign vggo_out   = vggo_out_r;
   assign halt_out   = halt_r;
   assign busy       = busy_r;
   assign seq_err    = seq_err_r;
   assign clip_count = clip_cnt_r;
   assign en_w       = en_w_r;
   assign w_addr     = w_addr_r;
   assign color_out  = color_r;

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Sits between the pixel sources and the frame-buffer controller's write port.
- Arbitrates pixel writes from two requesters: the vector-generator line drawer and an overlay source (score/radar).
- Converts (x,y) into a linear address, clips off-screen pixels and buffers accepted pixels in a small FIFO.
- Sequences the frame handshake: forwards vggo to start a back-buffer frame, and on frame-done drains the FIFO before pulsing halt so no pixel lands after the buffer swap.

Parameters:
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, >= 4.
- H_RES, 640, visible columns; linear address = y*H_RES + x.
- V_RES, 480, visible rows.
- SWAP_WAIT, 3, cycles held in SWAP after the halt pulse; covers the controller's halt-edge-to-buffer-switch delay.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- vg_valid  in  1  line-drawer pixel valid.
- vg_ready  out  1  line-drawer pixel accepted this cycle when high with vg_valid.
- vg_x  in  10  line-drawer column.
- vg_y  in  9  line-drawer row.
- vg_color  in  4  line-drawer intensity.
- ov_valid  in  1  overlay pixel valid.
- ov_ready  out  1  overlay pixel accepted.
- ov_x  in  10  overlay column.
- ov_y  in  9  overlay row.
- ov_color  in  4  overlay intensity.
- vggo_in  in  1  level; rising edge requests frame start.
- frame_done  in  1  level; rising edge means the drawer has finished this frame.
- vggo_out  out  1  one-cycle frame-start pulse to the frame-buffer controller.
- halt_out  out  1  one-cycle swap pulse to the frame-buffer controller.
- en_w  out  1  frame-buffer write enable.
- w_addr  out  19  frame-buffer write address.
- color_out  out  4  frame-buffer write data.
- busy  out  1  high in every state except IDLE.
- clip_count  out  16  count of clipped pixels this frame; saturates at 0xFFFF.
- seq_err  out  1  sticky flag: vggo edge seen while not IDLE.

Behaviour:
- Reset, in the cycle after rst is high:
  - All outputs are 0, state is IDLE, FIFO is empty, address stage is invalid.
  - Edge detectors are cleared; the round-robin pointer favours vg.
- Edge detection on vggo_in and frame_done uses a registered previous value (rise = cur & ~prev).
- States: IDLE, RUN, DRAIN, SWAP.
  - IDLE:
    - On a vggo rise, pulse vggo_out the same cycle, clear clip_count, go to RUN.
    - A frame_done rise in IDLE is ignored.
  - RUN:
    - Accept pixels.
    - On a frame_done rise, go to DRAIN. A handshake in that same cycle is still accepted; none are accepted afterwards.
  - DRAIN:
    - No acceptance.
    - When the address stage is invalid and the FIFO is empty, pulse halt_out for one cycle and go to SWAP.
  - SWAP:
    - Count SWAP_WAIT cycles, then go to IDLE.
    - A vggo rise during SWAP sets seq_err and is dropped.
- A vggo rise in RUN or DRAIN sets seq_err. seq_err is cleared only by rst.
- Acceptance rule: space = FIFO count + stage_valid < FIFO_DEPTH. A requester's ready = (state==RUN) & space & grant.
- Arbitration:
  - If only one requester is valid, it is granted.
  - If both are valid, round-robin: grant the requester not granted at the last two-way contention.
  - ready is combinational from valid, state and space; no valid-to-ready loop exists through other requesters.
- Address stage, cycle after a handshake:
  - If x < H_RES and y < V_RES: register addr = y*H_RES + x (19 bits, max 307199) with colour, and mark the stage valid.
  - Otherwise: do not mark the stage valid, and increment clip_count (saturating).
- FIFO:
  - A valid stage writes the FIFO at the end of its cycle.
  - The FIFO pops one entry per cycle when non-empty.
  - The pop registers en_w=1, w_addr and color_out.
  - Latency from handshake to en_w with an empty FIFO is exactly 3 cycles: handshake N, stage N+1, FIFO N+2, en_w at N+3.
  - Sustained throughput is 1 pixel/cycle with no bubbles.
- en_w is 0 whenever no pop occurred. w_addr and color_out hold their last value when en_w=0.
- Never overflows: the space check guarantees this. Count wraps are not possible.
- frame_done and vggo rises in the same cycle: handled per current state as above. In RUN this means DRAIN plus seq_err.

Decomposition:
- Package fb_pkg:
  - H_RES, V_RES, FB_WORDS=307200.
  - typedef sched_state_t (IDLE, RUN, DRAIN, SWAP).
  - typedef struct pix_t {addr[18:0], color[3:0]}.
- Sub-module fb_pix_fifo:
  - Synchronous first-word-fall-through FIFO of pix_t, parameter DEPTH.
  - Ports: push, pop, dout, count, empty, full.
  - Synchronous active-high reset.

Test Plan:
- Reset, vggo rise, one vg pixel (x=5, y=2, color=9) -> vggo_out pulse, then en_w=1 exactly 3 cycles after the handshake with w_addr=1285 and color_out=9; busy=1.
- Both requesters valid continuously for 8 cycles -> grants alternate vg, ov, vg, ...; en_w is high on 8 consecutive cycles; addresses appear in grant order.
- Pixel at x=640, y=0 and pixel at x=0, y=480 -> no en_w for either; clip_count=2; the next vggo clears it to 0.
- Hold ov_valid with en_w draining -> at most FIFO_DEPTH pixels in flight; ready drops at FIFO_DEPTH-1 stored plus 1 staged; no pixel is lost (count en_w pulses equals accepted handshakes).
- frame_done rise with 5 pixels queued -> ready=0 immediately; 5 en_w pulses; halt_out pulses on the cycle after the last drain condition is met; busy falls SWAP_WAIT cycles later.
- vggo rise during RUN, and rst asserted during DRAIN -> seq_err=1; after rst, all outputs are 0, state IDLE, FIFO empty, and no stale en_w appears.
